device_fetch: RTL and testbench
===============================

Name: device_fetch

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register (device_pc) and also produces that register's next-value input.
- Each cycle it reads the current PC, issues a read to the synchronous instruction memory, and computes the next PC: increment, hold, or redirect.
- Returned instructions go into a 2-entry buffer and are handed to decode with a valid/ready handshake. The PC of each instruction travels with it.

Parameters:
- PC_BITS, 8, width of PC and instruction-memory address (256-word instruction memory).
- INSTR_BITS, 16, instruction word width.
- RESET_PC, 0, PC value driven to the PC register during reset and boot.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_pc  in  PC_BITS  current PC, taken from the PC register output.
- o_next_pc  out  PC_BITS  next PC, driven to the PC register data input. The PC register loads every clock.
- o_imem_req  out  1  instruction-memory read strobe.
- o_imem_addr  out  PC_BITS  read address; always equals i_pc.
- i_imem_data  in  INSTR_BITS  read data; valid exactly 1 cycle after o_imem_req.
- i_halt  in  1  stop issuing new fetches.
- i_redirect  in  1  branch/jump taken; flush the stage.
- i_redirect_pc  in  PC_BITS  redirect target.
- o_instr  out  INSTR_BITS  instruction at the buffer head.
- o_instr_pc  out  PC_BITS  PC of o_instr.
- o_instr_valid  out  1  buffer head is valid.
- i_instr_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Clocking and reset:
  - One clock domain. Synchronous active-high reset on i_clk.
  - While i_rst is high:
    - o_next_pc = RESET_PC.
    - o_imem_req = 0.
    - o_instr_valid = 0; o_instr = 0; o_instr_pc = 0.
    - Buffer count = 0; in-flight flag = 0; state = S_BOOT.
- State machine:
  - S_BOOT: no request is issued and o_next_pc = RESET_PC. Move to S_RUN next cycle, so the PC register now holds RESET_PC.
  - S_RUN: normal fetch. i_halt=1 moves to S_HALT.
  - S_HALT: no requests are issued; o_next_pc = i_pc (hold). The buffer keeps draining. i_halt=0 returns to S_RUN.
- Pop: pop = o_instr_valid && i_instr_ready.
- Issue rule, S_RUN only:
  - issue = !i_redirect && (count + inflight - pop) < 2.
  - With 1-cycle memory this sustains 1 instruction/cycle while decode is ready.
- Next PC:
  - issue=1 → o_next_pc = i_pc + 1, modulo 2^PC_BITS (255 wraps to 0).
  - issue=0 → o_next_pc = i_pc.
- In-flight tracking:
  - On issue, register inflight=1 and inflight_pc=i_pc.
  - Next cycle, push {i_imem_data, inflight_pc} into the buffer and clear inflight unless a new issue occurs.
- Buffer:
  - 2-entry FIFO.
  - Push and pop in the same cycle are both honoured.
  - The credit rule guarantees a push never meets a full buffer. A push-when-full is an assertion failure.
  - Empty → o_instr_valid=0.
  - A push into an empty buffer is visible on o_instr the following cycle. There is no combinational bypass.
- Redirect (highest priority, any state except reset):
  - o_next_pc = i_redirect_pc; no issue that cycle.
  - Buffer is flushed (count=0).
  - An in-flight response arriving next cycle is discarded.
  - The handshake is ignored: o_instr_valid drops to 0 the cycle after the redirect.
  - Fetch resumes at i_redirect_pc in the following cycle, if not halted.
- Simultaneous events:
  - redirect + halt: redirect applies, then state = S_HALT.
  - redirect in S_BOOT: S_BOOT still completes, and o_next_pc = RESET_PC wins.
- Reset mid-operation: all state is cleared immediately at the next edge. Any in-flight data is dropped.
- Latency: PC visible on i_pc at cycle t → o_instr_valid at t+2.

Decomposition:
- Shared package/include holds:
  - INST_MEM_DEPTH, PC_BITS, INSTR_BITS.
  - State encodings S_BOOT=0, S_RUN=1, S_HALT=2.
  - Buffer depth constant FETCH_BUF_DEPTH=2.
- One sub-module: fetch_buffer, a 2-entry FIFO carrying {instr, pc} with push, pop, flush, count, head outputs.

Test Plan:
- Reset then release, memory word[n]=0x1000+n, ready=1 → o_next_pc=0 during boot. Decode sees (pc 0, 0x1000), (1, 0x1001), (2, 0x1002) on consecutive cycles, first at 2 cycles after boot.
- Ready held 0 from PC 5 → buffer fills with pcs 5 and 6. o_next_pc holds 7 and no req while full. Ready=1 → 5, 6, 7 delivered with no loss or duplicate.
- Redirect to 0x40 while pcs 10/11 are buffered and 12 is in flight → valid drops next cycle. Next instruction out is pc 0x40; pcs 10–12 are never delivered.
- PC 254 running → addresses 254, 255, 0, 1 delivered in order (wrap).
- i_halt=1 at PC 20 → no req; o_next_pc=20 held; buffer drains. Release → fetch resumes at 20.
- i_rst asserted with buffer full and a request in flight → next cycle valid=0, o_next_pc=RESET_PC. After release the first instruction delivered is pc 0.

Source files
------------

// File: rtl/device_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package device_fetch_pkg;

    localparam int PC_BITS         = 8;
    localparam int INSTR_BITS      = 16;
    localparam int INST_MEM_DEPTH  = 1 << PC_BITS;
    localparam int FETCH_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/device_fetch_buffer.sv
// Two-entry FIFO holding fetched {instr, pc} pairs; head is read from registers.
module fetch_buffer
    import device_fetch_pkg::*;
#(
    parameter int PC_BITS    = 8,
    parameter int INSTR_BITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [INSTR_BITS-1:0] i_push_instr,
    input  logic [PC_BITS-1:0]    i_push_pc,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [1:0]            o_count,
    output logic [INSTR_BITS-1:0] o_head_instr,
    output logic [PC_BITS-1:0]    o_head_pc
);

    localparam int PTR_BITS = $clog2(FETCH_BUF_DEPTH);

    logic [INSTR_BITS-1:0] instr_q [FETCH_BUF_DEPTH];
    logic [INSTR_BITS-1:0] instr_d [FETCH_BUF_DEPTH];
    logic [PC_BITS-1:0]    pc_q    [FETCH_BUF_DEPTH];
    logic [PC_BITS-1:0]    pc_d    [FETCH_BUF_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;

    // Pointer/count update; flush discards everything including a same-cycle push.
    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = i_pop && (count_q != 2'd0);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 2'd0;
        end else begin
            if (i_push) begin
                instr_d[wr_ptr_q] = i_push_instr;
                pc_d[wr_ptr_q]    = i_push_pc;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + 2'(i_push) - 2'(do_pop);
        end
    end

    // Storage and pointer registers; entry data needs no reset since count gates it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 2'd0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The fetch credit rule must never let a response arrive at a full buffer.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_flush && count_q == 2'(FETCH_BUF_DEPTH)));

    assign o_count      = count_q;
    assign o_head_instr = instr_q[rd_ptr_q];
    assign o_head_pc    = pc_q[rd_ptr_q];

endmodule

// File: rtl/device_fetch.sv
// Instruction-fetch stage: drives the PC register input, issues instruction
// memory reads, and buffers returned words for decode.
module device_fetch
    import device_fetch_pkg::*;
#(
    parameter int                 PC_BITS    = device_fetch_pkg::PC_BITS,
    parameter int                 INSTR_BITS = device_fetch_pkg::INSTR_BITS,
    parameter logic [PC_BITS-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PC_BITS-1:0]    i_pc,
    output logic [PC_BITS-1:0]    o_next_pc,
    output logic                  o_imem_req,
    output logic [PC_BITS-1:0]    o_imem_addr,
    input  logic [INSTR_BITS-1:0] i_imem_data,
    input  logic                  i_halt,
    input  logic                  i_redirect,
    input  logic [PC_BITS-1:0]    i_redirect_pc,
    output logic [INSTR_BITS-1:0] o_instr,
    output logic [PC_BITS-1:0]    o_instr_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready
);

    // Decode handshake: an instruction transfers in any cycle where
    // o_instr_valid && i_instr_ready; o_instr/o_instr_pc are stable while
    // valid is high and not accepted. A redirect overrides the handshake.

    fetch_state_e          state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [PC_BITS-1:0]    inflight_pc_q, inflight_pc_d;
    logic [1:0]            buf_count;
    logic [INSTR_BITS-1:0] head_instr;
    logic [PC_BITS-1:0]    head_pc;
    logic                  instr_valid;
    logic                  pop;
    logic                  issue;
    logic                  redirect_eff;
    logic                  push;
    logic [2:0]            occupancy;

    // Redirects are ignored until boot has completed.
    assign redirect_eff = i_redirect && !i_rst && (state_q != S_BOOT);
    assign instr_valid  = (buf_count != 2'd0) && !i_rst;
    assign pop          = instr_valid && i_instr_ready;
    assign occupancy    = {1'b0, buf_count} + {2'b0, inflight_q};
    assign issue        = !i_rst && (state_q == S_RUN) && !i_redirect
                          && (occupancy < 3'd2 + {2'b0, pop});
    // A response belonging to a flushed fetch is dropped on arrival.
    assign push         = inflight_q && !redirect_eff;

    // FSM transitions, in-flight tracking and next-PC selection.
    always_comb begin
        state_d       = state_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? i_pc : inflight_pc_q;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (i_halt) state_d = S_HALT;
            S_HALT:  if (!i_halt) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        if (i_rst || state_q == S_BOOT) begin
            o_next_pc = RESET_PC;
        end else if (i_redirect) begin
            o_next_pc = i_redirect_pc;
        end else if (issue) begin
            o_next_pc = i_pc + 1'b1;
        end else begin
            o_next_pc = i_pc;
        end
    end

    // State and in-flight registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_BOOT;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buffer #(
        .PC_BITS    (PC_BITS),
        .INSTR_BITS (INSTR_BITS)
    ) u_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (push),
        .i_push_instr (i_imem_data),
        .i_push_pc    (inflight_pc_q),
        .i_pop        (pop),
        .i_flush      (redirect_eff),
        .o_count      (buf_count),
        .o_head_instr (head_instr),
        .o_head_pc    (head_pc)
    );

    assign o_imem_req    = issue;
    assign o_imem_addr   = i_pc;
    assign o_instr_valid = instr_valid;
    assign o_instr       = instr_valid ? head_instr : '0;
    assign o_instr_pc    = instr_valid ? head_pc : '0;

endmodule

// File: tb/tb_device_fetch.sv
// Bench for device_fetch with a PC register and 1-cycle instruction memory model.
module tb_device_fetch;

    logic        clk;
    logic        i_rst;
    logic [7:0]  pc_reg;
    logic [7:0]  o_next_pc;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic [15:0] imem_data;
    logic        i_halt;
    logic        i_redirect;
    logic [7:0]  i_redirect_pc;
    logic [15:0] o_instr;
    logic [7:0]  o_instr_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;

    logic [15:0] imem [256];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    logic        s_valid;
    logic        s_req;
    logic [7:0]  s_next;
    logic [7:0]  s_addr;
    logic [7:0]  s_pc;
    logic [15:0] s_instr;

    typedef struct {
        logic       rst;
        logic       ready;
        logic [7:0] exp_next;
        logic       exp_req;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs [15];

    device_fetch #(
        .PC_BITS    (8),
        .INSTR_BITS (16),
        .RESET_PC   (8'd0)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_pc          (pc_reg),
        .o_next_pc     (o_next_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_data   (imem_data),
        .i_halt        (i_halt),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register loads every clock; memory returns data one cycle after a request.
    always @(posedge clk) begin
        pc_reg <= o_next_pc;
        if (o_imem_req) imem_data <= imem[o_imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, record transfers.
    task automatic cycle(input logic rst, input logic halt, input logic redir,
                         input logic [7:0] rpc, input logic ready);
        i_rst         = rst;
        i_halt        = halt;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_instr_ready = ready;
        @(negedge clk);
        s_valid = o_instr_valid;
        s_req   = o_imem_req;
        s_next  = o_next_pc;
        s_addr  = o_imem_addr;
        s_pc    = o_instr_pc;
        s_instr = o_instr;
        if (s_valid) check("instr_data", s_instr, 16'h1000 + {8'h00, s_pc});
        if (s_valid && ready && !redir && !rst) got_q.push_back(s_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic ready);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00, ready);
    endtask

    task automatic compare_deliveries(input string name);
        int n;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check({name, "_pc"}, got_q[k], exp_q[k]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int n = 0; n < 256; n++) imem[n] = 16'h1000 + 16'(n);
        imem_data     = 16'h0000;
        i_rst         = 1'b1;
        i_halt        = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 8'h00;
        i_instr_ready = 1'b1;

        // rst, ready, next, req, addr, valid, head pc
        vecs[0]  = '{1'b1, 1'b1, 8'd0,  1'b0, 8'd0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'd0,  1'b0, 8'd0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'd0,  1'b0, 8'd0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 8'd1,  1'b1, 8'd0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'd2,  1'b1, 8'd1, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'd3,  1'b1, 8'd2, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'd4,  1'b1, 8'd3, 1'b1, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 8'd5,  1'b1, 8'd4, 1'b1, 8'd2};
        vecs[8]  = '{1'b0, 1'b1, 8'd6,  1'b1, 8'd5, 1'b1, 8'd3};
        vecs[9]  = '{1'b0, 1'b1, 8'd7,  1'b1, 8'd6, 1'b1, 8'd4};
        vecs[10] = '{1'b0, 1'b0, 8'd7,  1'b0, 8'd0, 1'b1, 8'd5};
        vecs[11] = '{1'b0, 1'b0, 8'd7,  1'b0, 8'd0, 1'b1, 8'd5};
        vecs[12] = '{1'b0, 1'b1, 8'd8,  1'b1, 8'd7, 1'b1, 8'd5};
        vecs[13] = '{1'b0, 1'b1, 8'd9,  1'b1, 8'd8, 1'b1, 8'd6};
        vecs[14] = '{1'b0, 1'b1, 8'd10, 1'b1, 8'd9, 1'b1, 8'd7};

        // Reset, boot, streaming and backpressure from PC 5.
        for (int v = 0; v < 15; v++) begin
            cycle(vecs[v].rst, 1'b0, 1'b0, 8'h00, vecs[v].ready);
            check("vec_next_pc", s_next, vecs[v].exp_next);
            check("vec_req", s_req, vecs[v].exp_req);
            check("vec_valid", s_valid, vecs[v].exp_valid);
            if (vecs[v].exp_req) check("vec_addr", s_addr, vecs[v].exp_addr);
            if (vecs[v].exp_valid) check("vec_instr_pc", s_pc, vecs[v].exp_pc);
            if (vecs[v].rst) begin
                check("vec_rst_instr", s_instr, 16'h0000);
                check("vec_rst_pc", s_pc, 8'h00);
            end
        end
        got_q.delete();

        // Redirect to 0x40 with pcs 10/11 buffered: they must never be delivered.
        run(2, 1'b1);
        run(1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
        check("redir_next_pc", s_next, 8'h40);
        check("redir_no_req", s_req, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("redir_valid_drop", s_valid, 1'b0);
        check("redir_resume_req", s_req, 1'b1);
        check("redir_resume_addr", s_addr, 8'h40);
        run(5, 1'b1);
        exp_q = '{8'd8, 8'd9, 8'h40, 8'h41, 8'h42, 8'h43};
        compare_deliveries("redir_seq");

        // Redirect with a response in flight, landing at 254 to exercise the wrap.
        cycle(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
        check("wrap_redir_next", s_next, 8'hFE);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("inflight_discard_valid", s_valid, 1'b0);
        check("wrap_addr_fe", s_addr, 8'hFE);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("wrap_next_pc", s_next, 8'h00);
        check("wrap_addr_ff", s_addr, 8'hFF);
        run(5, 1'b1);
        exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        compare_deliveries("wrap_seq");

        // Halt at PC 20 while the buffer holds 18/19, drain, then release.
        cycle(1'b0, 1'b0, 1'b1, 8'd18, 1'b1);
        run(1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("halt_entry_next", s_next, 8'd20);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("halt_no_req", s_req, 1'b0);
        check("halt_hold_pc", s_next, 8'd20);
        check("halt_head_pc", s_pc, 8'd18);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("halt_drain_no_req", s_req, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("halt_drain_next", s_next, 8'd20);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        check("halt_drained", s_valid, 1'b0);
        check("halt_still_held", s_next, 8'd20);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("halt_release_no_req", s_req, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("resume_req", s_req, 1'b1);
        check("resume_addr", s_addr, 8'd20);
        run(3, 1'b1);
        exp_q = '{8'd18, 8'd19, 8'd20, 8'd21};
        compare_deliveries("halt_seq");

        // Reset with a full buffer; first delivery afterwards must be pc 0.
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("fill_no_req", s_req, 1'b0);
        check("fill_hold_pc", s_next, 8'd24);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("mid_rst_next", s_next, 8'h00);
        check("mid_rst_req", s_req, 1'b0);
        check("mid_rst_valid", s_valid, 1'b0);
        check("mid_rst_instr", s_instr, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst_valid", s_valid, 1'b0);
        check("post_rst_boot_next", s_next, 8'h00);
        check("post_rst_boot_req", s_req, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("post_rst_req", s_req, 1'b1);
        check("post_rst_addr", s_addr, 8'h00);
        run(3, 1'b1);
        exp_q = '{8'h00, 8'h01};
        compare_deliveries("rst_seq");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
